// File: rtl/rf_access_sequencer_pkg.sv
// rf_access_sequencer_pkg: shared widths and FSM state encoding for the register-file access sequencer
package rf_access_sequencer_pkg;
  localparam int DATA_INDEX_LIMIT = 31;
  localparam int REG_ADDR_INDEX_LIMIT = 4;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    HOLD = 2'd2,
    WR   = 2'd3
  } seq_state_t;
endpackage

// File: rtl/rf_seq_latch.sv
// rf_seq_latch: enable-loaded register with asynchronous active-low clear
module rf_seq_latch #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge CLK or negedge RST)
    if (!RST) q <= '0;
    else if (en) q <= d;
endmodule

// File: rtl/rf_access_sequencer.sv
// rf_access_sequencer: serialises operand reads and writebacks onto the register file; RF_SEQ_STATS_EN adds access counters
import rf_access_sequencer_pkg::*;
module rf_access_sequencer #(
  parameter int DATA_W = DATA_INDEX_LIMIT + 1,
  parameter int ADDR_W = REG_ADDR_INDEX_LIMIT + 1,
  parameter bit ZERO_REG_RO = 1'b1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_rs,
  input  logic [ADDR_W-1:0] req_rt,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [DATA_W-1:0] op_r1,
  output logic [DATA_W-1:0] op_r2,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic [ADDR_W-1:0] rf_addr_r1,
  output logic [ADDR_W-1:0] rf_addr_r2,
  output logic [ADDR_W-1:0] rf_addr_w,
  output logic [DATA_W-1:0] rf_data_w,
  output logic              rf_read,
  output logic              rf_write,
  input  logic [DATA_W-1:0] rf_data_r1,
  input  logic [DATA_W-1:0] rf_data_r2
`ifdef RF_SEQ_STATS_EN
  ,
  output logic [15:0]       stat_reads,
  output logic [15:0]       stat_writes
`endif
);
  seq_state_t state, state_nxt;
  logic take_wb, take_req;
  always_ff @(posedge CLK or negedge RST)
    if (!RST) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    take_wb   = state == IDLE && wb_valid;
    take_req  = state == IDLE && !wb_valid && req_valid;
    wb_ready  = state == IDLE;
    req_ready = state == IDLE && !wb_valid;
    op_valid  = state == HOLD;
    rf_read   = state == RD;
    // a write to r0 is acknowledged but never reaches the register file
    rf_write  = state == WR && !(ZERO_REG_RO && rf_addr_w == '0);
    state_nxt = take_wb ? WR : take_req ? RD : state == RD ? HOLD :
                state == HOLD && !op_ready ? HOLD : IDLE;
  end
  rf_seq_latch #(.W(2*ADDR_W)) u_src (
    .CLK(CLK), .RST(RST), .en(take_req), .d({req_rs, req_rt}), .q({rf_addr_r1, rf_addr_r2})
  );
  rf_seq_latch #(.W(ADDR_W+DATA_W)) u_wb (
    .CLK(CLK), .RST(RST), .en(take_wb), .d({wb_addr, wb_data}), .q({rf_addr_w, rf_data_w})
  );
  rf_seq_latch #(.W(2*DATA_W)) u_op (
    .CLK(CLK), .RST(RST), .en(rf_read), .d({rf_data_r1, rf_data_r2}), .q({op_r1, op_r2})
  );
`ifdef RF_SEQ_STATS_EN
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      stat_reads  <= '0;
      stat_writes <= '0;
    end else begin
      stat_reads  <= stat_reads + 16'(rf_read);
      stat_writes <= stat_writes + 16'(rf_write);
    end
`endif
endmodule

// File: tb/tb_rf_access_sequencer.sv
// tb_rf_access_sequencer: directed checks of the sequencer against a behavioural register file
module tb_rf_access_sequencer;
  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        req_valid = 1'b0, op_ready = 1'b0, wb_valid = 1'b0;
  logic [4:0]  req_rs = '0, req_rt = '0, wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic        req_ready, op_valid, wb_ready, rf_read, rf_write;
  logic [31:0] op_r1, op_r2, rf_data_w, rf_data_r1, rf_data_r2;
  logic [4:0]  rf_addr_r1, rf_addr_r2, rf_addr_w;
  logic [31:0] mem [32];
  int passed = 0, total = 0;

  rf_access_sequencer dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_rs(req_rs), .req_rt(req_rt),
    .op_valid(op_valid), .op_ready(op_ready), .op_r1(op_r1), .op_r2(op_r2),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
    .rf_addr_r1(rf_addr_r1), .rf_addr_r2(rf_addr_r2), .rf_addr_w(rf_addr_w),
    .rf_data_w(rf_data_w), .rf_read(rf_read), .rf_write(rf_write),
    .rf_data_r1(rf_data_r1), .rf_data_r2(rf_data_r2)
  );

  always #5 CLK = ~CLK;

  // behavioural register file, preloaded with recognisable contents while reset is low
  always @(posedge CLK or negedge RST)
    if (!RST) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'h1000_0000 + 32'(i);
      mem[0] <= 32'h0BAD_F00D;
      mem[7] <= 32'h1234_5678;
    end else if (rf_write) mem[rf_addr_w] <= rf_data_w;
  assign rf_data_r1 = mem[rf_addr_r1];
  assign rf_data_r2 = mem[rf_addr_r2];

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    #3;
    total++;
    if ({rf_read, rf_write, op_valid} !== 3'b000) $display("FAIL reset_ctrl: got %b want 000", {rf_read, rf_write, op_valid});
    else passed++;
    total++;
    if ({rf_addr_r1, rf_addr_r2, rf_addr_w, rf_data_w, op_r1, op_r2} !== '0)
      $display("FAIL reset_data: got %h want 0", {rf_addr_r1, rf_addr_r2, rf_addr_w, rf_data_w, op_r1, op_r2});
    else passed++;
    tick();
    RST = 1'b1;
    tick();
    req_valid = 1'b1; req_rs = 5'd4; req_rt = 5'd6;
    tick();
    req_valid = 1'b0;
    total++;
    if (rf_read !== 1'b1) $display("FAIL reset_pre_rd: rf_read got %b want 1", rf_read);
    else passed++;
    #2 RST = 1'b0;
    #1;
    total++;
    if ({rf_read, op_valid} !== 2'b00) $display("FAIL reset_async: rf_read,op_valid got %b want 00", {rf_read, op_valid});
    else passed++;
    tick();
    RST = 1'b1;
    tick();
    total++;
    if ({wb_ready, req_ready, rf_read, rf_write, op_valid} !== 5'b11000)
      $display("FAIL reset_idle: got %b want 11000", {wb_ready, req_ready, rf_read, rf_write, op_valid});
    else passed++;
    total++;
    if ({rf_addr_r1, rf_addr_r2} !== 10'd0) $display("FAIL reset_latch: got %h want 0", {rf_addr_r1, rf_addr_r2});
    else passed++;
  endtask

  task automatic test_write;
    wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEAD_BEEF;
    #1;
    total++;
    if ({wb_ready, req_ready} !== 2'b10) $display("FAIL wr_ready: got %b want 10", {wb_ready, req_ready});
    else passed++;
    tick();
    wb_valid = 1'b0;
    total++;
    if ({rf_write, rf_read, wb_ready} !== 3'b100) $display("FAIL wr_ctrl: got %b want 100", {rf_write, rf_read, wb_ready});
    else passed++;
    total++;
    if (rf_addr_w !== 5'd5 || rf_data_w !== 32'hDEAD_BEEF)
      $display("FAIL wr_pins: got %0d/%h want 5/deadbeef", rf_addr_w, rf_data_w);
    else passed++;
    tick();
    total++;
    if ({rf_write, wb_ready} !== 2'b01) $display("FAIL wr_done: got %b want 01", {rf_write, wb_ready});
    else passed++;
    total++;
    if (rf_addr_w !== 5'd5 || rf_data_w !== 32'hDEAD_BEEF)
      $display("FAIL wr_hold: got %0d/%h want 5/deadbeef", rf_addr_w, rf_data_w);
    else passed++;
  endtask

  task automatic test_read;
    req_valid = 1'b1; req_rs = 5'd5; req_rt = 5'd7;
    #1;
    total++;
    if (req_ready !== 1'b1) $display("FAIL rd_ready: got %b want 1", req_ready);
    else passed++;
    tick();
    req_valid = 1'b0;
    total++;
    if ({rf_read, rf_write, op_valid} !== 3'b100) $display("FAIL rd_ctrl: got %b want 100", {rf_read, rf_write, op_valid});
    else passed++;
    total++;
    if (rf_addr_r1 !== 5'd5 || rf_addr_r2 !== 5'd7) $display("FAIL rd_addr: got %0d/%0d want 5/7", rf_addr_r1, rf_addr_r2);
    else passed++;
    tick();
    total++;
    if ({op_valid, rf_read, req_ready, wb_ready} !== 4'b1000)
      $display("FAIL rd_hold_ctrl: got %b want 1000", {op_valid, rf_read, req_ready, wb_ready});
    else passed++;
    total++;
    if (op_r1 !== 32'hDEAD_BEEF || op_r2 !== 32'h1234_5678)
      $display("FAIL rd_ops: got %h/%h want deadbeef/12345678", op_r1, op_r2);
    else passed++;
    op_ready = 1'b1;
    tick();
    op_ready = 1'b0;
    total++;
    if ({op_valid, req_ready} !== 2'b01) $display("FAIL rd_release: got %b want 01", {op_valid, req_ready});
    else passed++;
  endtask

  task automatic test_wb_priority;
    wb_valid = 1'b1; wb_addr = 5'd3; wb_data = 32'hA5A5_A5A5;
    req_valid = 1'b1; req_rs = 5'd3; req_rt = 5'd7;
    #1;
    total++;
    if ({wb_ready, req_ready} !== 2'b10) $display("FAIL pri_ready: got %b want 10", {wb_ready, req_ready});
    else passed++;
    tick();
    wb_valid = 1'b0;
    total++;
    if ({rf_write, rf_read, req_ready} !== 3'b100) $display("FAIL pri_wr: got %b want 100", {rf_write, rf_read, req_ready});
    else passed++;
    tick();
    total++;
    if ({req_ready, rf_write, rf_read} !== 3'b100) $display("FAIL pri_idle: got %b want 100", {req_ready, rf_write, rf_read});
    else passed++;
    tick();
    req_valid = 1'b0;
    total++;
    if (rf_read !== 1'b1 || rf_addr_r1 !== 5'd3) $display("FAIL pri_rd: got %b/%0d want 1/3", rf_read, rf_addr_r1);
    else passed++;
    tick();
    total++;
    if (op_valid !== 1'b1 || op_r1 !== 32'hA5A5_A5A5 || op_r2 !== 32'h1234_5678)
      $display("FAIL pri_ops: got %b %h/%h want 1 a5a5a5a5/12345678", op_valid, op_r1, op_r2);
    else passed++;
    op_ready = 1'b1;
    tick();
    op_ready = 1'b0;
  endtask

  task automatic test_hold_stable;
    req_valid = 1'b1; req_rs = 5'd1; req_rt = 5'd2;
    tick();
    req_valid = 1'b0;
    tick();
    wb_valid = 1'b1; wb_addr = 5'd1; wb_data = 32'h5555_0000;
    req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      total++;
      if ({op_valid, req_ready, wb_ready, rf_read, rf_write} !== 5'b10000)
        $display("FAIL hold_ctrl[%0d]: got %b want 10000", i, {op_valid, req_ready, wb_ready, rf_read, rf_write});
      else passed++;
      total++;
      if (op_r1 !== 32'h1000_0001 || op_r2 !== 32'h1000_0002)
        $display("FAIL hold_ops[%0d]: got %h/%h want 10000001/10000002", i, op_r1, op_r2);
      else passed++;
      tick();
    end
    wb_valid = 1'b0; req_valid = 1'b0;
    op_ready = 1'b1;
    tick();
    op_ready = 1'b0;
    total++;
    if ({op_valid, wb_ready} !== 2'b01) $display("FAIL hold_release: got %b want 01", {op_valid, wb_ready});
    else passed++;
  endtask

  task automatic test_zero_reg;
    wb_valid = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFF_FFFF;
    #1;
    total++;
    if (wb_ready !== 1'b1) $display("FAIL zero_ready: got %b want 1", wb_ready);
    else passed++;
    tick();
    wb_valid = 1'b0;
    total++;
    if ({rf_write, rf_read} !== 2'b00) $display("FAIL zero_wr: got %b want 00", {rf_write, rf_read});
    else passed++;
    tick();
    total++;
    if (rf_write !== 1'b0) $display("FAIL zero_after: rf_write got %b want 0", rf_write);
    else passed++;
    req_valid = 1'b1; req_rs = 5'd0; req_rt = 5'd5;
    tick();
    req_valid = 1'b0;
    tick();
    total++;
    if (op_valid !== 1'b1 || op_r1 !== 32'h0BAD_F00D || op_r2 !== 32'hDEAD_BEEF)
      $display("FAIL zero_read: got %b %h/%h want 1 0badf00d/deadbeef", op_valid, op_r1, op_r2);
    else passed++;
    op_ready = 1'b1;
    tick();
    op_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_wb_priority();
    test_hold_stable();
    test_zero_reg();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
